// File: rtl/noc_run_ctrl_pkg.sv
// Shared definitions for the NoC run controller: phase encodings, error bit
// indices and the popcount helper used to count per-cycle packet events.
package noc_run_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WARMUP = 3'd1,
    ST_RUN    = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam int ERR_SAT   = 0;
  localparam int ERR_UNDER = 1;

  // Widest event vector popcount accepts; callers zero-extend narrower vectors.
  localparam int POP_MAX = 256;
  localparam int POP_W   = 9;

  function automatic logic [POP_W-1:0] popcount(input logic [POP_MAX-1:0] v);
    logic [POP_W-1:0] c;
    c = '0;
    for (int i = 0; i < POP_MAX; i++) begin
      c = c + POP_W'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/noc_sat_counter.sv
// Saturating up-counter with synchronous clear and a sticky saturation flag.
// Used for the global packet/cycle counters and the optional per-node counters.
module noc_sat_counter #(
  parameter int W  = 32,
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          a_rst,
  input  logic          clr,
  input  logic          en,
  input  logic [AW-1:0] add,
  output logic [W-1:0]  cnt,
  output logic          sat
);

  localparam int SW = W + AW;

  logic [SW-1:0] sum;
  logic          over;

  assign sum  = SW'(cnt) + SW'(add);
  assign over = |sum[SW-1:W];

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (en) begin
      if (over) begin
        cnt <= '1;
        sat <= 1'b1;
      end else begin
        cnt <= sum[W-1:0];
      end
    end
  end

endmodule

// File: rtl/noc_run_ctrl.sv
// Run controller for NoC traffic experiments: WARMUP/RUN/DRAIN gating, packet
// statistics and drain completion. Define NOC_RUN_CTRL_PERNODE_EN for per-node counters.
module noc_run_ctrl
  import noc_run_ctrl_pkg::*;
#(
  parameter int NODES_NUM   = 16,
  parameter int ADDR_SIZE   = 4,
  parameter int CNT_W       = 32,
  parameter int WARMUP_CLKS = 100,
  parameter int RUN_CLKS    = 10000,
  parameter int DRAIN_CLKS  = 2000
) (
  input  logic                 clk,
  input  logic                 a_rst,
  input  logic                 start,
  input  logic [NODES_NUM-1:0] tx_pack_v,
  input  logic [NODES_NUM-1:0] rx_pack_v,
  input  logic [ADDR_SIZE-1:0] stat_sel,
  output logic [NODES_NUM-1:0] gen_en,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout,
  output logic [1:0]           err,
  output logic [CNT_W-1:0]     total_tx,
  output logic [CNT_W-1:0]     total_rx,
  output logic [CNT_W-1:0]     run_cycles,
  output logic [CNT_W-1:0]     stat_tx,
  output logic [CNT_W-1:0]     stat_rx
);

  localparam int OW = CNT_W + POP_W;

  state_t             state_q, state_d;
  logic [31:0]        phase_q;
  logic               start_acc;
  logic               drain_to;
  logic               measure;
  logic [POP_W-1:0]   tx_cnt, rx_cnt;
  logic [CNT_W-1:0]   outstanding, out_d;
  logic [OW-1:0]      out_up, out_diff;
  logic               out_under, out_over;
  logic [1:0]         err_q;
  logic               tx_sat, rx_sat, rc_sat, pn_sat;

  // True on the last cycle of a phase lasting n cycles (zero-length counts as one).
  function automatic logic phase_end(input logic [31:0] ph, input int n);
    return ({1'b0, ph} + 33'd1) >= 33'(n);
  endfunction

  assign tx_cnt  = popcount(POP_MAX'(tx_pack_v));
  assign rx_cnt  = popcount(POP_MAX'(rx_pack_v));
  assign busy    = (state_q == ST_WARMUP) || (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done    = (state_q == ST_DONE);
  assign measure = (state_q == ST_RUN) || (state_q == ST_DRAIN);

  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    drain_to  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          start_acc = 1'b1;
          state_d   = (WARMUP_CLKS == 0) ? ST_RUN : ST_WARMUP;
        end
      end
      ST_WARMUP: if (phase_end(phase_q, WARMUP_CLKS)) state_d = ST_RUN;
      ST_RUN:    if (phase_end(phase_q, RUN_CLKS)) state_d = ST_DRAIN;
      ST_DRAIN: begin
        // An empty fabric wins over a coincident drain timeout.
        if (outstanding == '0) begin
          state_d = ST_DONE;
        end else if (phase_end(phase_q, DRAIN_CLKS)) begin
          state_d  = ST_DONE;
          drain_to = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outstanding packets net injections against consumptions in the same cycle.
  assign out_up   = OW'(outstanding) + OW'(tx_cnt);
  assign out_diff = out_up - OW'(rx_cnt);

  always_comb begin
    out_d     = outstanding;
    out_under = 1'b0;
    out_over  = 1'b0;
    if (out_up < OW'(rx_cnt)) begin
      out_d     = '0;
      out_under = 1'b1;
    end else if (|out_diff[OW-1:CNT_W]) begin
      out_d    = '1;
      out_over = 1'b1;
    end else begin
      out_d = out_diff[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      state_q     <= ST_IDLE;
      phase_q     <= '0;
      gen_en      <= '0;
      timeout     <= 1'b0;
      err_q       <= '0;
      outstanding <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) begin
        phase_q <= '0;
      end else if (busy) begin
        phase_q <= phase_q + 32'd1;
      end
      gen_en <= ((state_d == ST_WARMUP) || (state_d == ST_RUN)) ? '1 : '0;
      if (start_acc) begin
        timeout     <= 1'b0;
        err_q       <= '0;
        outstanding <= '0;
      end else begin
        if (drain_to) timeout <= 1'b1;
        if (busy) begin
          outstanding <= out_d;
          if (out_under) err_q[ERR_UNDER] <= 1'b1;
          if (out_over)  err_q[ERR_SAT]   <= 1'b1;
        end
      end
    end
  end

  noc_sat_counter #(.W(CNT_W), .AW(POP_W)) u_total_tx (
    .clk(clk), .a_rst(a_rst), .clr(start_acc), .en(measure),
    .add(tx_cnt), .cnt(total_tx), .sat(tx_sat)
  );

  noc_sat_counter #(.W(CNT_W), .AW(POP_W)) u_total_rx (
    .clk(clk), .a_rst(a_rst), .clr(start_acc), .en(measure),
    .add(rx_cnt), .cnt(total_rx), .sat(rx_sat)
  );

  noc_sat_counter #(.W(CNT_W), .AW(POP_W)) u_run_cycles (
    .clk(clk), .a_rst(a_rst), .clr(start_acc), .en(measure),
    .add(POP_W'(1)), .cnt(run_cycles), .sat(rc_sat)
  );

  always_comb begin
    err            = '0;
    err[ERR_UNDER] = err_q[ERR_UNDER];
    err[ERR_SAT]   = err_q[ERR_SAT] | tx_sat | rx_sat | rc_sat | pn_sat;
  end

`ifdef NOC_RUN_CTRL_PERNODE_EN
  logic [CNT_W-1:0]     node_tx [NODES_NUM];
  logic [CNT_W-1:0]     node_rx [NODES_NUM];
  logic [NODES_NUM-1:0] node_tx_sat, node_rx_sat;
  logic [CNT_W-1:0]     sel_tx, sel_rx;

  for (genvar n = 0; n < NODES_NUM; n++) begin : g_node
    noc_sat_counter #(.W(CNT_W), .AW(1)) u_tx (
      .clk(clk), .a_rst(a_rst), .clr(start_acc), .en(measure),
      .add(tx_pack_v[n]), .cnt(node_tx[n]), .sat(node_tx_sat[n])
    );
    noc_sat_counter #(.W(CNT_W), .AW(1)) u_rx (
      .clk(clk), .a_rst(a_rst), .clr(start_acc), .en(measure),
      .add(rx_pack_v[n]), .cnt(node_rx[n]), .sat(node_rx_sat[n])
    );
  end

  // Indices past the last node match nothing and read back as zero.
  always_comb begin
    sel_tx = '0;
    sel_rx = '0;
    for (int n = 0; n < NODES_NUM; n++) begin
      if (stat_sel == ADDR_SIZE'(n)) begin
        sel_tx = node_tx[n];
        sel_rx = node_rx[n];
      end
    end
  end

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      stat_tx <= '0;
      stat_rx <= '0;
    end else begin
      stat_tx <= sel_tx;
      stat_rx <= sel_rx;
    end
  end

  assign pn_sat = |{node_tx_sat, node_rx_sat};
`else
  logic unused_stat_sel;

  assign unused_stat_sel = ^stat_sel;
  assign stat_tx         = '0;
  assign stat_rx         = '0;
  assign pn_sat          = 1'b0;
`endif

endmodule

// File: tb/tb_noc_run_ctrl.sv
// Bench for noc_run_ctrl: a wide-counter and a 4-bit-counter instance share the
// same stimulus and are compared every cycle against a phase-level reference model.
module tb_noc_run_ctrl;

  localparam int N  = 16;
  localparam int AS = 5;
  localparam int WB = 16;
  localparam int WS = 4;
  localparam int WU = 2;
  localparam int RN = 5;
  localparam int DR = 4;

`ifdef NOC_RUN_CTRL_PERNODE_EN
  localparam bit PERNODE = 1'b1;
`else
  localparam bit PERNODE = 1'b0;
`endif

  localparam int P_IDLE = 0, P_WARM = 1, P_RUN = 2, P_DRAIN = 3, P_DONE = 4;

  logic          clk = 1'b0;
  logic          a_rst = 1'b0;
  logic          start = 1'b0;
  logic [N-1:0]  tx_pack_v = '0;
  logic [N-1:0]  rx_pack_v = '0;
  logic [AS-1:0] stat_sel = '0;

  logic [N-1:0]  gen_en_b, gen_en_s;
  logic          busy_b, busy_s, done_b, done_s, timeout_b, timeout_s;
  logic [1:0]    err_b, err_s;
  logic [WB-1:0] ttx_b, trx_b, rc_b, stx_b, srx_b;
  logic [WS-1:0] ttx_s, trx_s, rc_s, stx_s, srx_s;

  noc_run_ctrl #(.NODES_NUM(N), .ADDR_SIZE(AS), .CNT_W(WB), .WARMUP_CLKS(WU),
                 .RUN_CLKS(RN), .DRAIN_CLKS(DR)) dut_b (
    .clk(clk), .a_rst(a_rst), .start(start), .tx_pack_v(tx_pack_v), .rx_pack_v(rx_pack_v),
    .stat_sel(stat_sel), .gen_en(gen_en_b), .busy(busy_b), .done(done_b), .timeout(timeout_b),
    .err(err_b), .total_tx(ttx_b), .total_rx(trx_b), .run_cycles(rc_b),
    .stat_tx(stx_b), .stat_rx(srx_b)
  );

  noc_run_ctrl #(.NODES_NUM(N), .ADDR_SIZE(AS), .CNT_W(WS), .WARMUP_CLKS(WU),
                 .RUN_CLKS(RN), .DRAIN_CLKS(DR)) dut_s (
    .clk(clk), .a_rst(a_rst), .start(start), .tx_pack_v(tx_pack_v), .rx_pack_v(rx_pack_v),
    .stat_sel(stat_sel), .gen_en(gen_en_s), .busy(busy_s), .done(done_s), .timeout(timeout_s),
    .err(err_s), .total_tx(ttx_s), .total_rx(trx_s), .run_cycles(rc_s),
    .stat_tx(stx_s), .stat_rx(srx_s)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state, index 0 = wide instance, 1 = 4-bit instance.
  int     m_ph[2];
  int     m_rem[2];
  longint m_out[2], m_ttx[2], m_trx[2], m_rc[2], m_stx[2], m_srx[2];
  bit     m_sat[2], m_und[2], m_to[2];
  longint m_ntx[2][N];
  longint m_nrx[2][N];

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear(input int k);
    m_out[k] = 0; m_ttx[k] = 0; m_trx[k] = 0; m_rc[k] = 0;
    m_sat[k] = 1'b0; m_und[k] = 1'b0; m_to[k] = 1'b0;
    for (int n = 0; n < N; n++) begin
      m_ntx[k][n] = 0;
      m_nrx[k][n] = 0;
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      model_clear(k);
      m_ph[k] = P_IDLE; m_rem[k] = 0; m_stx[k] = 0; m_srx[k] = 0;
    end
  endtask

  task automatic model_step(input int k, input logic st, input logic [N-1:0] tx,
                            input logic [N-1:0] rx, input logic [AS-1:0] sel);
    longint mx;
    longint o;
    longint old_out;
    int     ctx, crx;
    bit     meas, live;
    mx      = (longint'(1) << ((k == 0) ? WB : WS)) - 1;
    ctx     = $countones(tx);
    crx     = $countones(rx);
    meas    = (m_ph[k] == P_RUN) || (m_ph[k] == P_DRAIN);
    live    = meas || (m_ph[k] == P_WARM);
    old_out = m_out[k];
    m_stx[k] = (int'(sel) < N) ? m_ntx[k][int'(sel)] : 0;
    m_srx[k] = (int'(sel) < N) ? m_nrx[k][int'(sel)] : 0;
    if (live) begin
      o = m_out[k] + ctx - crx;
      if (o < 0) begin o = 0; m_und[k] = 1'b1; end
      else if (o > mx) begin o = mx; m_sat[k] = 1'b1; end
      m_out[k] = o;
    end
    if (meas) begin
      m_ttx[k] += ctx; m_trx[k] += crx; m_rc[k] += 1;
      if (m_ttx[k] > mx) begin m_ttx[k] = mx; m_sat[k] = 1'b1; end
      if (m_trx[k] > mx) begin m_trx[k] = mx; m_sat[k] = 1'b1; end
      if (m_rc[k] > mx) begin m_rc[k] = mx; m_sat[k] = 1'b1; end
      for (int n = 0; n < N; n++) begin
        m_ntx[k][n] += longint'(tx[n]);
        m_nrx[k][n] += longint'(rx[n]);
        if (m_ntx[k][n] > mx) m_ntx[k][n] = mx;
        if (m_nrx[k][n] > mx) m_nrx[k][n] = mx;
      end
    end
    case (m_ph[k])
      P_IDLE, P_DONE: begin
        if (st) begin
          model_clear(k);
          if (WU == 0) begin m_ph[k] = P_RUN; m_rem[k] = RN; end
          else begin m_ph[k] = P_WARM; m_rem[k] = WU; end
        end
      end
      P_WARM: begin
        m_rem[k]--;
        if (m_rem[k] <= 0) begin m_ph[k] = P_RUN; m_rem[k] = RN; end
      end
      P_RUN: begin
        m_rem[k]--;
        if (m_rem[k] <= 0) begin m_ph[k] = P_DRAIN; m_rem[k] = DR; end
      end
      default: begin
        if (old_out == 0) begin
          m_ph[k] = P_DONE;
        end else begin
          m_rem[k]--;
          if (m_rem[k] <= 0) begin m_ph[k] = P_DONE; m_to[k] = 1'b1; end
        end
      end
    endcase
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      longint ge, b, d, t, e, a_ttx, a_trx, a_rc, a_stx, a_srx, ones;
      if (k == 0) begin
        ge = longint'(gen_en_b); b = longint'(busy_b); d = longint'(done_b);
        t = longint'(timeout_b); e = longint'(err_b); a_ttx = longint'(ttx_b);
        a_trx = longint'(trx_b); a_rc = longint'(rc_b); a_stx = longint'(stx_b);
        a_srx = longint'(srx_b);
      end else begin
        ge = longint'(gen_en_s); b = longint'(busy_s); d = longint'(done_s);
        t = longint'(timeout_s); e = longint'(err_s); a_ttx = longint'(ttx_s);
        a_trx = longint'(trx_s); a_rc = longint'(rc_s); a_stx = longint'(stx_s);
        a_srx = longint'(srx_s);
      end
      ones = (longint'(1) << N) - 1;
      chk($sformatf("gen_en[%0d]", k), ge,
          ((m_ph[k] == P_WARM) || (m_ph[k] == P_RUN)) ? ones : 64'd0);
      chk($sformatf("busy[%0d]", k), b,
          ((m_ph[k] == P_WARM) || (m_ph[k] == P_RUN) || (m_ph[k] == P_DRAIN)) ? 64'd1 : 64'd0);
      chk($sformatf("done[%0d]", k), d, (m_ph[k] == P_DONE) ? 64'd1 : 64'd0);
      chk($sformatf("timeout[%0d]", k), t, longint'(m_to[k]));
      chk($sformatf("err[%0d]", k), e, longint'({m_und[k], m_sat[k]}));
      chk($sformatf("total_tx[%0d]", k), a_ttx, m_ttx[k]);
      chk($sformatf("total_rx[%0d]", k), a_trx, m_trx[k]);
      chk($sformatf("run_cycles[%0d]", k), a_rc, m_rc[k]);
      chk($sformatf("stat_tx[%0d]", k), a_stx, PERNODE ? m_stx[k] : 64'd0);
      chk($sformatf("stat_rx[%0d]", k), a_srx, PERNODE ? m_srx[k] : 64'd0);
    end
  endtask

  task automatic cycle(input logic st, input logic [N-1:0] tx, input logic [N-1:0] rx,
                       input logic [AS-1:0] sel);
    start     = st;
    tx_pack_v = tx;
    rx_pack_v = rx;
    stat_sel  = sel;
    model_step(0, st, tx, rx, sel);
    model_step(1, st, tx, rx, sel);
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int gcnt, bcnt;
    logic [N-1:0] tx, rx;

    // Reset state
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    @(negedge clk);
    a_rst = 1'b1;
    check_all();
    chk("rst_gen_en", longint'(gen_en_b), 64'd0);

    // Idle run: gate width and run_cycles start
    gcnt = 0;
    bcnt = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(i == 0, '0, '0, 5'd5);
      if (gen_en_b == '1) gcnt++;
      if (busy_b) bcnt++;
      if (i == 2) chk("A_rc_first_run", longint'(rc_b), 64'd0);
      if (i == 3) chk("A_rc_counting", longint'(rc_b), 64'd1);
    end
    chk("A_gen_cycles", longint'(gcnt), 64'd7);
    chk("A_busy_cycles", longint'(bcnt), 64'd8);
    chk("A_done", longint'(done_b), 64'd1);
    chk("A_run_cycles", longint'(rc_b), 64'd6);

    // One packet in flight, delivered before drain
    for (int i = 0; i < 10; i++) begin
      cycle(i == 0, (i == 3) ? 16'h0001 : 16'h0000, (i == 6) ? 16'h0008 : 16'h0000, 5'd5);
      if (i == 7) chk("B_busy_drain", longint'(busy_b), 64'd1);
      if (i == 8) chk("B_done_first_drain", longint'(done_b), 64'd1);
    end
    chk("B_total_tx", longint'(ttx_b), 64'd1);
    chk("B_total_rx", longint'(trx_b), 64'd1);
    chk("B_timeout", longint'(timeout_b), 64'd0);

    // Drain timeout with one packet lost
    for (int i = 0; i < 13; i++) begin
      tx = (i == 3) ? 16'h000F : 16'h0000;
      rx = (i == 4) ? 16'h0001 : (i == 5) ? 16'h0002 : (i == 6) ? 16'h0004 : 16'h0000;
      cycle(i == 0, tx, rx, 5'd5);
      if (i == 10) chk("C_not_done", longint'(done_b), 64'd0);
      if (i == 11) chk("C_done_after_drain", longint'(done_b), 64'd1);
    end
    chk("C_timeout", longint'(timeout_b), 64'd1);
    chk("C_total_rx", longint'(trx_b), 64'd3);
    chk("C_total_tx", longint'(ttx_b), 64'd4);

    // Netting and underflow
    for (int i = 0; i < 10; i++) begin
      tx = (i == 1) ? 16'h0003 : 16'h0000;
      rx = ((i >= 1) && (i <= 3)) ? 16'h0001 : 16'h0000;
      cycle(i == 0, tx, rx, 5'd5);
      if (i == 2) chk("D_no_underflow", longint'(err_b[1]), 64'd0);
      if (i == 3) chk("D_underflow", longint'(err_b[1]), 64'd1);
    end
    chk("D_done_empty", longint'(done_b), 64'd1);
    chk("D_timeout", longint'(timeout_b), 64'd0);

    // Saturation on the 4-bit instance
    for (int i = 0; i < 13; i++) begin
      cycle(i == 0, ((i >= 3) && (i <= 7)) ? 16'h000F : 16'h0000, '0, 5'd5);
    end
    chk("E_sat_total_tx", longint'(ttx_s), 64'd15);
    chk("E_sat_err0", longint'(err_s[0]), 64'd1);
    chk("E_wide_total_tx", longint'(ttx_b), 64'd20);
    chk("E_wide_err0", longint'(err_b[0]), 64'd0);

    // Restart from DONE clears, then per-node readout
    for (int i = 0; i < 12; i++) begin
      cycle(i == 0, ((i >= 3) && (i <= 5)) ? 16'h0020 : 16'h0000, '0, 5'd5);
      if (i == 0) begin
        chk("F_clr_total_tx", longint'(ttx_s), 64'd0);
        chk("F_clr_err", longint'(err_s), 64'd0);
        chk("F_clr_timeout", longint'(timeout_b), 64'd0);
      end
    end
    cycle(1'b0, '0, '0, 5'd5);
    chk("F_stat_tx_node5", longint'(stx_b), PERNODE ? 64'd3 : 64'd0);
    cycle(1'b0, '0, '0, 5'd20);
    chk("F_stat_tx_oob", longint'(stx_b), 64'd0);

    // Asynchronous reset in the middle of RUN
    for (int i = 0; i < 5; i++) begin
      cycle(i == 0, N'($urandom), N'($urandom), 5'd5);
    end
    #2;
    a_rst = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_mid_busy", longint'(busy_b), 64'd0);
    @(negedge clk);
    start = 1'b0;
    a_rst = 1'b1;
    check_all();

    // Randomised traffic, stray starts and readout indices
    for (int i = 0; i < 300; i++) begin
      cycle($urandom_range(0, 11) == 0, N'($urandom & $urandom), N'($urandom & $urandom),
            AS'($urandom_range(0, 31)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
